mms_4num_stream_loader: RTL and testbench

//  Stream front-end for the 4-input max/min selector. Accepts 8-bit numbers serially over a

---
 rtl/mms_4num_stream_loader_if.sv | 24 ++
 rtl/mms_4num_stream_loader.sv | 107 ++++++++++
 tb/tb_mms_4num_stream_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mms_4num_stream_loader_if.sv
// Handshake bundle for the MMS_4num stream loader: serial operand input and registered result output.
interface mms_4num_stream_loader_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_select;
  logic              in_flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_select;

  modport master (
    output in_valid, in_data, in_select, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_select
  );

  modport slave (
    input  in_valid, in_data, in_select, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_select
  );
endinterface

// File: rtl/mms_4num_stream_loader.sv
// Packs serial 8-bit operands into groups of four for an external MMS_4num and
// registers its combinational max/min result onto a valid/ready output.
module mms_4num_stream_loader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mms_4num_stream_loader_if.slave bus,
  output logic                   mms_select,
  output logic [DATA_W-1:0]      mms_num0,
  output logic [DATA_W-1:0]      mms_num1,
  output logic [DATA_W-1:0]      mms_num2,
  output logic [DATA_W-1:0]      mms_num3,
  input  logic [DATA_W-1:0]      mms_result,
  output logic [CNT_W-1:0]       groups_done
);

  typedef enum logic [1:0] {COLLECT, EVAL, HOLD} state_t;

  state_t            state, state_nxt;
  logic [1:0]        slot_cnt_p0;
  logic [DATA_W-1:0] slot_p0 [4];
  logic              sel_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] out_data_p1;
  logic              out_sel_p1;
  logic [CNT_W-1:0]  groups_done_q;
  logic              accept;
  logic              last_beat;
  logic              sel_eff;

  // Neutral element for the selected operation: 0 never wins a max, all-ones never wins a min.
  function automatic logic [DATA_W-1:0] pad_value(input logic sel);
    return sel ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = ~rst;
        if (accept && last_beat) state_nxt = EVAL;
      end
      EVAL:    state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = (slot_cnt_p0 == 2'd3) || bus.in_flush;
  // The first beat of a group carries the select that the padding must honour.
  assign sel_eff   = (slot_cnt_p0 == 2'd0) ? bus.in_select : sel_p0;

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Stage p0: operand collection slots feeding MMS_4num
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_p0 <= 2'd0;
      sel_p0      <= 1'b0;
      for (int i = 0; i < 4; i++) slot_p0[i] <= '0;
    end else if (accept) begin
      slot_p0[slot_cnt_p0] <= bus.in_data;
      if (slot_cnt_p0 == 2'd0) sel_p0 <= bus.in_select;
      if (last_beat) slot_cnt_p0 <= 2'd0;
      else           slot_cnt_p0 <= slot_cnt_p0 + 2'd1;
      if (bus.in_flush) begin
        for (int i = 0; i < 4; i++)
          if (2'(i) > slot_cnt_p0) slot_p0[i] <= pad_value(sel_eff);
      end
    end
  end

  // Stage p1: registered result held until the downstream handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      out_data_p1   <= '0;
      out_sel_p1    <= 1'b0;
      groups_done_q <= '0;
    end else if (state == EVAL) begin
      vld_p1      <= 1'b1;
      out_data_p1 <= mms_result;
      out_sel_p1  <= sel_p0;
    end else if (vld_p1 && bus.out_ready) begin
      vld_p1        <= 1'b0;
      groups_done_q <= groups_done_q + 1'b1;
    end
  end

  assign mms_select     = sel_p0;
  assign mms_num0       = slot_p0[0];
  assign mms_num1       = slot_p0[1];
  assign mms_num2       = slot_p0[2];
  assign mms_num3       = slot_p0[3];
  assign bus.out_valid  = vld_p1;
  assign bus.out_data   = out_data_p1;
  assign bus.out_select = out_sel_p1;
  assign groups_done    = groups_done_q;

endmodule

// File: tb/tb_mms_4num_stream_loader.sv
// Directed bench for mms_4num_stream_loader with a behavioural MMS_4num on the side.
module tb_mms_4num_stream_loader;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mms_4num_stream_loader_if #(.DATA_W(DATA_W)) bus();

  logic              mms_select;
  logic [DATA_W-1:0] mms_num0, mms_num1, mms_num2, mms_num3;
  logic [DATA_W-1:0] mms_result;
  logic [CNT_W-1:0]  groups_done;

  mms_4num_stream_loader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .mms_select (mms_select),
    .mms_num0   (mms_num0),
    .mms_num1   (mms_num1),
    .mms_num2   (mms_num2),
    .mms_num3   (mms_num3),
    .mms_result (mms_result),
    .groups_done(groups_done)
  );

  // Behavioural MMS_4num: select=0 max, select=1 min
  logic [DATA_W-1:0] mx, mn;
  always_comb begin
    mx = mms_num0;
    mn = mms_num0;
    if (mms_num1 > mx) mx = mms_num1;
    if (mms_num2 > mx) mx = mms_num2;
    if (mms_num3 > mx) mx = mms_num3;
    if (mms_num1 < mn) mn = mms_num1;
    if (mms_num2 < mn) mn = mms_num2;
    if (mms_num3 < mn) mn = mms_num3;
    mms_result = mms_select ? mn : mx;
  end

  typedef struct {
    int          n;
    logic [3:0]  sel;        // per-beat select, beat0 in the MSB
    logic [31:0] d;          // beat0 in the top byte
    bit          flush;      // flush on the final beat
    logic [7:0]  exp_out;
    logic        exp_sel;
    logic [31:0] exp_slots;  // slot0 in the top byte
  } vec_t;

  vec_t vecs [8];
  int   checks = 0;
  int   passed = 0;
  int   exp_gd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic f);
    int t = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_select = s;
    bus.in_flush  = f;
    while (!bus.in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 20) chk("beat_accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_flush = 1'b0;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n:4, sel:4'b0000, d:32'h129A057F, flush:1'b0, exp_out:8'h9A, exp_sel:1'b0, exp_slots:32'h129A057F};
    vecs[1] = '{n:4, sel:4'b1111, d:32'h4003FE03, flush:1'b0, exp_out:8'h03, exp_sel:1'b1, exp_slots:32'h4003FE03};
    vecs[2] = '{n:2, sel:4'b1100, d:32'h80900000, flush:1'b1, exp_out:8'h80, exp_sel:1'b1, exp_slots:32'h8090FFFF};
    vecs[3] = '{n:1, sel:4'b0000, d:32'h00000000, flush:1'b1, exp_out:8'h00, exp_sel:1'b0, exp_slots:32'h00000000};
    vecs[4] = '{n:4, sel:4'b0111, d:32'h01020304, flush:1'b0, exp_out:8'h04, exp_sel:1'b0, exp_slots:32'h01020304};
    vecs[5] = '{n:4, sel:4'b1111, d:32'h5A5A5A5A, flush:1'b0, exp_out:8'h5A, exp_sel:1'b1, exp_slots:32'h5A5A5A5A};
    vecs[6] = '{n:4, sel:4'b0000, d:32'h010203FF, flush:1'b1, exp_out:8'hFF, exp_sel:1'b0, exp_slots:32'h010203FF};
    vecs[7] = '{n:1, sel:4'b1000, d:32'h7C000000, flush:1'b1, exp_out:8'h7C, exp_sel:1'b1, exp_slots:32'h7CFFFFFF};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_select = 1'b0;
    bus.in_flush  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst out_select", bus.out_select, 0);
    chk("rst groups_done", groups_done, 0);
    chk("rst mms_num0", mms_num0, 0);
    chk("rst mms_select", mms_select, 0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", bus.in_ready, 1);

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].n; i++)
        beat(vecs[v].d[31-8*i -: 8], vecs[v].sel[3-i], (i == vecs[v].n - 1) && vecs[v].flush);
      chk($sformatf("v%0d eval out_valid", v), bus.out_valid, 0);
      chk($sformatf("v%0d eval in_ready", v), bus.in_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", v), bus.out_valid, 1);
      chk($sformatf("v%0d out_data", v), bus.out_data, vecs[v].exp_out);
      chk($sformatf("v%0d out_select", v), bus.out_select, vecs[v].exp_sel);
      chk($sformatf("v%0d mms_select", v), mms_select, vecs[v].exp_sel);
      chk($sformatf("v%0d slot0", v), mms_num0, vecs[v].exp_slots[31:24]);
      chk($sformatf("v%0d slot1", v), mms_num1, vecs[v].exp_slots[23:16]);
      chk($sformatf("v%0d slot2", v), mms_num2, vecs[v].exp_slots[15:8]);
      chk($sformatf("v%0d slot3", v), mms_num3, vecs[v].exp_slots[7:0]);
      handshake();
      exp_gd++;
      chk($sformatf("v%0d post-hs out_valid", v), bus.out_valid, 0);
      chk($sformatf("v%0d post-hs in_ready", v), bus.in_ready, 1);
      chk($sformatf("v%0d groups_done", v), groups_done, exp_gd);
    end

    // Backpressure: result must hold and input must stall while out_ready is low
    beat(8'h10, 1'b0, 1'b0);
    beat(8'h20, 1'b0, 1'b0);
    beat(8'h30, 1'b0, 1'b0);
    beat(8'h40, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp out_valid", bus.out_valid, 1);
      chk("bp out_data", bus.out_data, 8'h40);
      chk("bp in_ready", bus.in_ready, 0);
      chk("bp slot0 untouched", mms_num0, 8'h10);
    end
    bus.in_valid = 1'b0;
    chk("bp groups_done held", groups_done, exp_gd);
    handshake();
    exp_gd++;
    chk("bp release out_valid", bus.out_valid, 0);
    chk("bp release in_ready", bus.in_ready, 1);
    chk("bp groups_done", groups_done, exp_gd);

    // Reset mid-group discards the partial group
    beat(8'h11, 1'b0, 1'b0);
    beat(8'h22, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst-mid in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst-mid slot0", mms_num0, 0);
    chk("rst-mid slot1", mms_num1, 0);
    chk("rst-mid groups_done", groups_done, 0);
    beat(8'h05, 1'b0, 1'b0);
    beat(8'h06, 1'b0, 1'b0);
    beat(8'h07, 1'b0, 1'b0);
    beat(8'h08, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst-mid regroup out_valid", bus.out_valid, 1);
    chk("rst-mid regroup out_data", bus.out_data, 8'h08);

    // Reset while holding a result drops it without a handshake
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst-hold out_valid", bus.out_valid, 0);
    chk("rst-hold out_data", bus.out_data, 0);
    chk("rst-hold groups_done", groups_done, 0);
    chk("rst-hold in_ready", bus.in_ready, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
